// File: rtl/core_pkg.sv
// Shared core definitions: field widths, the canonical NOP encoding and the
// pipeline-stage state encoding.
package core_pkg;

    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } stage_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the pipeline stage: a load-enabled register that
// clears to zero on synchronous active-low reset.
module pipe_slot #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (ld_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage holding PC, instruction and sideband.
// Define PIPE_SKID_BUF_EN to add a skid entry and register in_ready_o.
module pipe_stage_hs
    import core_pkg::*;
#(
    parameter int unsigned PC_W    = PC_WIDTH,
    parameter int unsigned INSTR_W = INSTR_WIDTH,
    parameter int unsigned SIDE_W  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PC_W-1:0]    in_pc_i,
    input  logic [INSTR_W-1:0] in_instr_i,
    input  logic [SIDE_W-1:0]  in_side_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    out_pc_o,
    output logic [INSTR_W-1:0] out_instr_o,
    output logic [SIDE_W-1:0]  out_side_o
);

    localparam int unsigned SLOT_W = PC_W + INSTR_W + SIDE_W;

    stage_state_e      state_d;
    stage_state_e      state_q;
    logic              accept;
    logic              drain;
    logic              main_ld;
    logic [SLOT_W-1:0] in_word;
    logic [SLOT_W-1:0] main_d_word;
    logic [SLOT_W-1:0] main_q_word;

    assign in_word     = {in_pc_i, in_instr_i, in_side_i};
    assign out_valid_o = (state_q != ST_EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;

`ifdef PIPE_SKID_BUF_EN
    logic              in_ready_d;
    logic              in_ready_q;
    logic              skid_ld;
    logic              main_from_skid;
    logic [SLOT_W-1:0] skid_q_word;

    // in_ready is derived from the next state so it is a pure register
    // output, decoupled from out_ready_i.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_ld = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_d = ST_SKID;
                        skid_ld = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_d        = ST_FULL;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != ST_SKID);
        main_d_word = main_from_skid ? skid_q_word : in_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o = in_ready_q;

    pipe_slot #(.W(SLOT_W)) u_skid_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (skid_ld),
        .d_i   (in_word),
        .q_o   (skid_q_word)
    );
`else
    always_comb begin
        state_d     = state_q;
        main_ld     = 1'b0;
        main_d_word = in_word;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
            main_ld = 1'b1;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready_o = (state_q == ST_EMPTY) | out_ready_i;
`endif

    pipe_slot #(.W(SLOT_W)) u_main_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (main_ld),
        .d_i   (main_d_word),
        .q_o   (main_q_word)
    );

    // PC keeps its last value when empty; instruction and sideband read as NOP.
    assign out_pc_o    = main_q_word[SLOT_W-1 -: PC_W];
    assign out_instr_o = out_valid_o ? main_q_word[SIDE_W +: INSTR_W] : INSTR_W'(INSTR_NOP);
    assign out_side_o  = out_valid_o ? main_q_word[SIDE_W-1:0] : '0;

endmodule
